dot_ctrl: RTL

Sequencer for the shared dot-product datapath: two synchronous single-port RAMs (vector A, vector B) feeding a registered signed multiplier and an accumulator. Accepts load and compute commands, writes element pairs into both RAMs, streams them back through the multiplier, accumulates products, and returns one signed result per compute command over a valid/ready handshake. Sits between the host command port and the external RAM/multiplier instances.

---
 rtl/dot_ctrl_pkg.sv | 21 ++
 rtl/dot_ctrl_if.sv | 33 +++
 rtl/dot_acc.sv | 72 +++++++
 rtl/dot_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/dot_ctrl_pkg.sv
// dot_pkg: shared types and defaults for the dot-product sequencer.
// Holds the controller state encoding, command opcodes and default widths.
package dot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic OP_LOAD    = 1'b0;
    localparam logic OP_COMPUTE = 1'b1;

    localparam int DEF_DW       = 16;
    localparam int DEF_AW       = 9;
    localparam int DEF_MULT_LAT = 1;
    localparam int DEF_ACC_W    = 40;

endpackage

// File: rtl/dot_ctrl_if.sv
// dot_ctrl_if: host-side bundle of the sequencer (command, element-pair load
// and result handshakes). master = host, slave = dot_ctrl.
interface dot_ctrl_if
    import dot_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int ACC_W = DEF_ACC_W
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [AW:0]      cmd_len;
    logic             load_valid;
    logic             load_ready;
    logic [DW-1:0]    a_in;
    logic [DW-1:0]    b_in;
    logic [ACC_W-1:0] result;
    logic             result_valid;
    logic             result_ready;

    modport master (
        output cmd_valid, cmd_op, cmd_len, load_valid, a_in, b_in, result_ready,
        input  cmd_ready, load_ready, result, result_valid
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, load_valid, a_in, b_in, result_ready,
        output cmd_ready, load_ready, result, result_valid
    );

endinterface

// File: rtl/dot_acc.sv
// dot_acc: in-flight valid delay line plus the product accumulator.
// A product is added in the cycle its tag reaches the end of the delay line.
// Build option DOTCTRL_SAT_EN: saturate (and stick) instead of wrapping.
module dot_acc
    import dot_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int ACC_W    = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             issue,
    input  logic [2*DW-1:0]  mult_p,
    output logic [ACC_W-1:0] acc,
    output logic             drained
);

    // index 0: operands on the multiplier inputs; index MULT_LAT: product ready
    logic [MULT_LAT:0]       vld_pipe;
    logic [ACC_W-1:0]        acc_q;
    logic signed [ACC_W-1:0] p_ext;
    logic                    add_en;

    assign p_ext   = ACC_W'($signed(mult_p));
    assign add_en  = vld_pipe[MULT_LAT];
    // Nothing left that can still reach the adder after this edge.
    assign drained = (vld_pipe[MULT_LAT-1:0] == '0);
    assign acc     = acc_q;

    // Shift one tag per cycle; a tag is injected for every issued read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[MULT_LAT-1:0], issue};
    end

`ifdef DOTCTRL_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] sum_w;
    logic           ovf;
    logic           sat_q;

    // One guard bit: overflow when the two top bits of the sum disagree.
    assign sum_w = {acc_q[ACC_W-1], acc_q} + {p_ext[ACC_W-1], p_ext};
    assign ovf   = sum_w[ACC_W] ^ sum_w[ACC_W-1];

    // Saturating accumulate; once clipped the value is frozen until clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (clr) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (add_en && !sat_q) begin
            acc_q <= ovf ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX) : sum_w[ACC_W-1:0];
            sat_q <= ovf;
        end
    end
`else
    // Wrapping accumulate (modulo 2^ACC_W).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      acc_q <= '0;
        else if (clr)    acc_q <= '0;
        else if (add_en) acc_q <= acc_q + p_ext;
    end
`endif

endmodule

// File: rtl/dot_ctrl.sv
// dot_ctrl: command sequencer for the shared dot-product datapath.
// LOAD writes element pairs into the A/B RAMs; COMPUTE streams them through
// the external multiplier into dot_acc and returns one result per command.
// Build option DOTCTRL_SAT_EN (in dot_acc): saturating accumulator.
module dot_ctrl
    import dot_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int ACC_W    = DEF_ACC_W
) (
    input  logic            clk,
    input  logic            reset,
    dot_ctrl_if.slave       host,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_di_a,
    output logic [DW-1:0]   ram_di_b,
    input  logic [DW-1:0]   ram_do_a,
    input  logic [DW-1:0]   ram_do_b,
    output logic [DW-1:0]   mult_a,
    output logic [DW-1:0]   mult_b,
    input  logic [2*DW-1:0] mult_p,
    output logic            busy
);

    localparam logic [AW:0] MAX_LEN = (AW+1)'(1) << AW;
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_e           state, state_nxt;
    logic [AW:0]      len_q, cnt_q, len_clamped;
    logic             cmd_fire, load_fire, last, issue, acc_clr, drained;
    logic [ACC_W-1:0] acc;

    assign len_clamped = (host.cmd_len > MAX_LEN) ? MAX_LEN : host.cmd_len;
    assign cmd_fire    = host.cmd_valid && host.cmd_ready;
    assign load_fire   = host.load_valid && (state == ST_LOAD);
    assign last        = (cnt_q + ONE) == len_q;
    assign issue       = (state == ST_RUN);

    // Held low while reset is asserted so nothing looks acceptable in reset.
    assign host.cmd_ready    = reset && (state == ST_IDLE);
    assign host.load_ready   = (state == ST_LOAD);
    assign host.result_valid = (state == ST_DONE);
    assign host.result       = acc;
    assign busy              = (state != ST_IDLE);

    assign ram_we   = load_fire;
    assign ram_addr = (state == ST_LOAD || state == ST_RUN) ? cnt_q[AW-1:0] : '0;
    assign ram_di_a = ram_we ? host.a_in : '0;
    assign ram_di_b = ram_we ? host.b_in : '0;
    assign mult_a   = ram_do_a;
    assign mult_b   = ram_do_b;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; the accumulator clear pulses on COMPUTE acceptance.
    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (host.cmd_op == OP_LOAD) begin
                        state_nxt = (len_clamped == '0) ? ST_IDLE : ST_LOAD;
                    end else begin
                        acc_clr   = 1'b1;
                        state_nxt = (len_clamped == '0) ? ST_DONE : ST_RUN;
                    end
                end
            end
            ST_LOAD:  if (load_fire && last)  state_nxt = ST_IDLE;
            ST_RUN:   if (last)               state_nxt = ST_DRAIN;
            ST_DRAIN: if (drained)            state_nxt = ST_DONE;
            ST_DONE:  if (host.result_ready)  state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    // Length latch and shared write/read index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q <= '0;
            cnt_q <= '0;
        end else if (cmd_fire) begin
            len_q <= len_clamped;
            cnt_q <= '0;
        end else if (load_fire || issue) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    dot_acc #(
        .DW       (DW),
        .MULT_LAT (MULT_LAT),
        .ACC_W    (ACC_W)
    ) u_acc (
        .clk     (clk),
        .reset   (reset),
        .clr     (acc_clr),
        .issue   (issue),
        .mult_p  (mult_p),
        .acc     (acc),
        .drained (drained)
    );

endmodule
